uart_dma_loader: RTL and testbench

- Sits directly upstream of the memory controller hub.
- Packs UART receive bytes into 32-bit words. After reset it runs a boot handshake and writes a length-prefixed program into instruction memory.
- After boot it streams every further word to the hub's DMA input (`data_ready`/`data`), which feeds the hub's receive ring buffer.
- It shares the UART transmitter with the hub. The block only drives the transmitter before `boot_done` rises, so the two never overlap.

---
 rtl/uart_dma_pkg.sv | 25 ++
 rtl/uart_dma_loader_if.sv | 44 ++++
 rtl/uart_byte_packer.sv | 85 ++++++++
 rtl/uart_dma_loader.sv | 177 +++++++++++++++++
 tb/tb_uart_dma_loader.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_dma_pkg
// Description : Shared types and constants for the UART boot loader / DMA
//               streamer. Holds the loader state encoding, the handshake bytes
//               sent to the host, and the 32-bit word type.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_dma_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    S_SEND_BOOT = 3'd0,
    S_LEN       = 3'd1,
    S_PROG      = 3'd2,
    S_SEND_DONE = 3'd3,
    S_STREAM    = 3'd4
  } state_t;

  localparam logic [7:0] ACK_BOOT = 8'h99;
  localparam logic [7:0] ACK_DONE = 8'hAA;

endpackage
`default_nettype wire

// File: rtl/uart_dma_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_dma_loader_if
// Description : Bundle of UART receive/transmit, instruction-memory write and
//               hub DMA signals around the loader.
//               master : the loader (drives tx, instr and data outputs)
//               slave  : the environment (UART, instruction memory, hub)
// Signals     : rx_ready/rdata/ferr   UART receive byte strobe, byte, framing err
//               tx_start/sdata/tx_busy UART transmit start pulse, byte, busy
//               instr_we/addr/wd      instruction-memory write port
//               data_ready/data       hub DMA word strobe and word
//               boot_done/len_err     status levels
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_dma_loader_if #(
  parameter int IADDR_W = 12
);
  logic                 rx_ready;
  logic [7:0]           rdata;
  logic                 ferr;
  logic                 tx_start;
  logic [7:0]           sdata;
  logic                 tx_busy;
  logic                 instr_we;
  logic [IADDR_W-1:0]   instr_addr;
  uart_dma_pkg::word_t  instr_wd;
  logic                 data_ready;
  uart_dma_pkg::word_t  data;
  logic                 boot_done;
  logic                 len_err;

  modport master (
    input  rx_ready, rdata, ferr, tx_busy,
    output tx_start, sdata, instr_we, instr_addr, instr_wd,
           data_ready, data, boot_done, len_err
  );

  modport slave (
    output rx_ready, rdata, ferr, tx_busy,
    input  tx_start, sdata, instr_we, instr_addr, instr_wd,
           data_ready, data, boot_done, len_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_packer
// Description : Packs received UART bytes little-endian into 32-bit words.
//               Bytes flagged with a framing error are dropped. word_valid is
//               high for the one cycle after the 4th good byte is sampled;
//               word holds the packed value in that cycle.
//               Optional macro UART_DMA_LOADER_RX_TIMEOUT_EN: a partial word
//               idle for TIMEOUT_CYCLES is discarded.
// Ports       : clock, reset (sync, active-high)
//               rx_ready, rdata, ferr  - receive byte interface
//               word_valid, word       - packed word output
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_packer
  import uart_dma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_ready,
  input  logic [7:0] rdata,
  input  logic       ferr,
  output logic       word_valid,
  output word_t      word
);

  logic [1:0] r_byte_cnt;
  word_t      r_shift;
  logic       r_word_valid;
  logic       w_byte_ok;
  logic       w_timeout;

  assign w_byte_ok = rx_ready && !ferr;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("uart_byte_packer: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef UART_DMA_LOADER_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_idle_cnt;

  // Counts idle cycles only while a word is partially assembled.
  always_ff @(posedge clock) begin
    if (reset || w_byte_ok || (r_byte_cnt == 2'd0)) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_byte_cnt != 2'd0) &&
                     (r_idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Right shift: the 1st byte enters at [31:24] and ends in [7:0] after the
  // 4th, so the shift register itself is the little-endian word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_byte_cnt   <= 2'd0;
      r_shift      <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (w_byte_ok) begin
        r_shift    <= {rdata, r_shift[31:8]};
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (r_byte_cnt == 2'd3) begin
          r_word_valid <= 1'b1;
        end
      end else if (w_timeout) begin
        r_byte_cnt <= 2'd0;
      end
    end
  end

  assign word_valid = r_word_valid;
  assign word       = r_shift;

endmodule
`default_nettype wire

// File: rtl/uart_dma_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_dma_loader
// Description : UART boot loader in front of the memory controller hub.
//               Sends ACK_BOOT, receives a length-prefixed program into
//               instruction memory, sends ACK_DONE, then streams every further
//               word to the hub DMA input. Drives the shared UART transmitter
//               only before boot_done rises.
//               Optional macro UART_DMA_LOADER_RX_TIMEOUT_EN enables the
//               partial-word receive timeout in the byte packer.
// Ports       : clock, reset (sync, active-high)
//               bus (uart_dma_loader_if.master) - UART rx/tx, instruction
//               write port, hub DMA port, boot_done and len_err status
// Revision    : 1.0 - initial release
// ============================================================================
module uart_dma_loader
  import uart_dma_pkg::*;
#(
  parameter int         MAX_PROG_WORDS = 4096,
  parameter int         IADDR_W        = 12,
  parameter logic [7:0] ACK_BOOT       = uart_dma_pkg::ACK_BOOT,
  parameter logic [7:0] ACK_DONE       = uart_dma_pkg::ACK_DONE,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clock,
  input  logic                   reset,
  uart_dma_loader_if.master      bus
);

  // One extra bit so the count can reach MAX_PROG_WORDS itself.
  localparam int CNT_W = IADDR_W + 1;

  logic       w_word_valid;
  word_t      w_word;

  state_t     r_state,     w_state_nx;
  logic [CNT_W-1:0] r_word_cnt, w_word_cnt_nx;
  logic [CNT_W-1:0] r_prog_len, w_prog_len_nx;
  logic [CNT_W-1:0] w_cnt_inc;
  logic       r_len_held,  w_len_held_nx;
  word_t      r_len_word,  w_len_word_nx;
  word_t      w_hdr;
  logic       r_tx_start,  w_tx_start_nx;
  logic [7:0] r_sdata,     w_sdata_nx;
  logic       r_len_err,   w_len_err_nx;
  logic       r_boot_done;
  logic       w_instr_we;
  logic       w_data_ready;

  uart_byte_packer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_packer (
    .clock      (clock),
    .reset      (reset),
    .rx_ready   (bus.rx_ready),
    .rdata      (bus.rdata),
    .ferr       (bus.ferr),
    .word_valid (w_word_valid),
    .word       (w_word)
  );

  assign w_cnt_inc = r_word_cnt + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_SEND_BOOT;
      r_word_cnt  <= '0;
      r_prog_len  <= '0;
      r_len_held  <= 1'b0;
      r_len_word  <= '0;
      r_tx_start  <= 1'b0;
      r_sdata     <= 8'h00;
      r_len_err   <= 1'b0;
      r_boot_done <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_word_cnt  <= w_word_cnt_nx;
      r_prog_len  <= w_prog_len_nx;
      r_len_held  <= w_len_held_nx;
      r_len_word  <= w_len_word_nx;
      r_tx_start  <= w_tx_start_nx;
      r_sdata     <= w_sdata_nx;
      r_len_err   <= w_len_err_nx;
      // Lags entry to S_STREAM by a cycle so the ACK_DONE pulse is never
      // seen together with boot_done.
      r_boot_done <= (r_state == S_STREAM);
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_word_cnt_nx = r_word_cnt;
    w_prog_len_nx = r_prog_len;
    w_len_held_nx = r_len_held;
    w_len_word_nx = r_len_word;
    w_tx_start_nx = 1'b0;
    w_sdata_nx    = r_sdata;
    w_len_err_nx  = r_len_err;
    w_instr_we    = 1'b0;
    w_data_ready  = 1'b0;
    w_hdr         = r_len_held ? r_len_word : w_word;

    case (r_state)
      S_SEND_BOOT: begin
        // A length word can complete before the transmitter frees up; park
        // it until S_LEN. Only the first such word is kept.
        if (w_word_valid && !r_len_held) begin
          w_len_held_nx = 1'b1;
          w_len_word_nx = w_word;
        end
        if (!bus.tx_busy && !r_tx_start) begin
          w_tx_start_nx = 1'b1;
          w_sdata_nx    = ACK_BOOT;
          w_state_nx    = S_LEN;
        end
      end

      S_LEN: begin
        if (w_word_valid || r_len_held) begin
          w_len_held_nx = 1'b0;
          w_word_cnt_nx = '0;
          if (w_hdr == 32'd0) begin
            w_state_nx = S_SEND_DONE;
          end else begin
            w_state_nx = S_PROG;
            if (w_hdr > 32'(MAX_PROG_WORDS)) begin
              w_len_err_nx  = 1'b1;
              w_prog_len_nx = CNT_W'(MAX_PROG_WORDS);
            end else begin
              w_prog_len_nx = w_hdr[CNT_W-1:0];
            end
          end
        end
      end

      S_PROG: begin
        if (w_word_valid) begin
          w_instr_we    = 1'b1;
          w_word_cnt_nx = w_cnt_inc;
          if (w_cnt_inc == r_prog_len) begin
            w_state_nx = S_SEND_DONE;
          end
        end
      end

      S_SEND_DONE: begin
        // Program is complete: any word now belongs to the stream.
        w_data_ready = w_word_valid;
        if (!bus.tx_busy && !r_tx_start) begin
          w_tx_start_nx = 1'b1;
          w_sdata_nx    = ACK_DONE;
          w_state_nx    = S_STREAM;
        end
      end

      S_STREAM: begin
        w_data_ready = w_word_valid;
      end

      default: begin
        w_state_nx = S_SEND_BOOT;
      end
    endcase
  end

  assign bus.tx_start   = r_tx_start;
  assign bus.sdata      = r_sdata;
  assign bus.instr_we   = w_instr_we;
  assign bus.instr_addr = r_word_cnt[IADDR_W-1:0];
  assign bus.instr_wd   = w_word;
  assign bus.data_ready = w_data_ready;
  assign bus.data       = w_word;
  assign bus.boot_done  = r_boot_done;
  assign bus.len_err    = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_dma_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_dma_loader
// Description : Directed self-checking bench for uart_dma_loader. A monitor
//               records every instr_we / data_ready / tx_start pulse into
//               queues; scenario tasks drive bytes and compare the recorded
//               traffic against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_dma_loader;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  uart_dma_loader_if #(.IADDR_W(12)) bus_if ();

  uart_dma_loader #(
    .MAX_PROG_WORDS (4096),
    .IADDR_W        (12),
    .ACK_BOOT       (8'h99),
    .ACK_DONE       (8'hAA),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int tests = 0;
  int fails = 0;

  logic [11:0] iq_addr[$];
  logic [31:0] iq_wd[$];
  logic [31:0] dq[$];
  logic [7:0]  txq[$];
  int          proto_err = 0;
  logic        prev_tx = 1'b0, prev_we = 1'b0, prev_dr = 1'b0;

  // Sample outputs 1 time unit after each rising edge; inputs only change on
  // falling edges.
  always begin
    @(posedge clock);
    #1;
    if (bus_if.instr_we) begin
      iq_addr.push_back(bus_if.instr_addr);
      iq_wd.push_back(bus_if.instr_wd);
    end
    if (bus_if.data_ready) dq.push_back(bus_if.data);
    if (bus_if.tx_start)   txq.push_back(bus_if.sdata);
    if (bus_if.instr_we && bus_if.data_ready) proto_err++;
    if (bus_if.tx_start && (prev_tx || bus_if.tx_busy || bus_if.boot_done)) proto_err++;
    if (bus_if.instr_we && prev_we) proto_err++;
    if (bus_if.data_ready && prev_dr) proto_err++;
    prev_tx = bus_if.tx_start;
    prev_we = bus_if.instr_we;
    prev_dr = bus_if.data_ready;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic fe);
    @(negedge clock);
    bus_if.rx_ready = 1'b1;
    bus_if.rdata    = b;
    bus_if.ferr     = fe;
    @(negedge clock);
    bus_if.rx_ready = 1'b0;
    bus_if.ferr     = 1'b0;
    bus_if.rdata    = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0],   1'b0);
    send_byte(w[15:8],  1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[31:24], 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus_if.rx_ready = 1'b0;
    bus_if.ferr     = 1'b0;
    repeat (3) @(negedge clock);
    iq_addr.delete(); iq_wd.delete(); dq.delete(); txq.delete();
    reset = 1'b0;
  endtask

  // Bounded wait for the first recorded tx_start.
  task automatic wait_tx(input int max_cyc, output logic got);
    for (int i = 0; i < max_cyc && txq.size() == 0; i++) @(negedge clock);
    got = (txq.size() != 0);
  endtask

  task automatic expect_ack(input string name, input logic [7:0] exp, input int max_cyc);
    logic got;
    wait_tx(max_cyc, got);
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s: no tx_start within %0d cycles, expected sdata %02h", name, max_cyc, exp);
    end else if (txq[0] !== exp) begin
      fails++;
      $display("FAIL %s: sdata %02h, expected %02h", name, txq[0], exp);
    end
    txq.delete();
  endtask

  task automatic test_reset();
    logic got;
    bus_if.rx_ready = 1'b0; bus_if.rdata = 8'h00; bus_if.ferr = 1'b0; bus_if.tx_busy = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clock);
    tests++;
    if ({bus_if.tx_start, bus_if.instr_we, bus_if.data_ready, bus_if.boot_done, bus_if.len_err} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %05b, expected 00000",
               {bus_if.tx_start, bus_if.instr_we, bus_if.data_ready, bus_if.boot_done, bus_if.len_err});
    end
    tests++;
    if (bus_if.sdata !== 8'h00 || bus_if.instr_addr !== 12'h000) begin
      fails++;
      $display("FAIL reset_sdata_addr: got %02h/%03h, expected 00/000", bus_if.sdata, bus_if.instr_addr);
    end
    tests++;
    if (bus_if.instr_wd !== 32'h0 || bus_if.data !== 32'h0) begin
      fails++;
      $display("FAIL reset_words: got %08h/%08h, expected 0/0", bus_if.instr_wd, bus_if.data);
    end
    txq.delete();
    reset = 1'b0;
    wait_tx(2, got);
    tests++;
    if (!got || txq[0] !== 8'h99) begin
      fails++;
      $display("FAIL boot_ack_fast: got tx=%0b, expected ACK_BOOT 99 within 2 cycles", got);
    end
    txq.delete();
  endtask

  task automatic test_program();
    send_word(32'h0000_0002);
    send_word(32'h4433_2211);
    send_word(32'h8877_6655);
    repeat (2) @(negedge clock);
    tests++;
    if (iq_addr.size() != 2) begin
      fails++;
      $display("FAIL prog_count: got %0d writes, expected 2", iq_addr.size());
    end else begin
      tests++;
      if (iq_addr[0] !== 12'd0 || iq_wd[0] !== 32'h44332211) begin
        fails++;
        $display("FAIL prog_word0: got %03h/%08h, expected 000/44332211", iq_addr[0], iq_wd[0]);
      end
      tests++;
      if (iq_addr[1] !== 12'd1 || iq_wd[1] !== 32'h88776655) begin
        fails++;
        $display("FAIL prog_word1: got %03h/%08h, expected 001/88776655", iq_addr[1], iq_wd[1]);
      end
    end
    expect_ack("prog_ack_done", 8'hAA, 6);
    repeat (2) @(negedge clock);
    tests++;
    if (bus_if.boot_done !== 1'b1 || bus_if.len_err !== 1'b0) begin
      fails++;
      $display("FAIL prog_status: boot_done/len_err %0b/%0b, expected 1/0", bus_if.boot_done, bus_if.len_err);
    end
  endtask

  task automatic test_stream();
    iq_addr.delete(); iq_wd.delete(); dq.delete();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    @(negedge clock);
    bus_if.rx_ready = 1'b1;
    bus_if.rdata    = 8'h04;
    @(posedge clock);
    #1;
    tests++;
    if (bus_if.data_ready !== 1'b1 || bus_if.data !== 32'h04030201) begin
      fails++;
      $display("FAIL stream_latency: data_ready/data %0b/%08h, expected 1/04030201", bus_if.data_ready, bus_if.data);
    end
    @(negedge clock);
    bus_if.rx_ready = 1'b0;
    @(posedge clock);
    #1;
    tests++;
    if (bus_if.data_ready !== 1'b0) begin
      fails++;
      $display("FAIL stream_pulse_width: data_ready %0b, expected 0", bus_if.data_ready);
    end
    repeat (3) @(negedge clock);
    tests++;
    if (dq.size() != 1 || iq_addr.size() != 0) begin
      fails++;
      $display("FAIL stream_counts: data %0d, instr %0d, expected 1, 0", dq.size(), iq_addr.size());
    end
  endtask

  task automatic test_boot_busy();
    bus_if.tx_busy = 1'b1;
    do_reset();
    repeat (50) @(negedge clock);
    tests++;
    if (txq.size() != 0) begin
      fails++;
      $display("FAIL busy_hold: %0d tx_start pulses while busy, expected 0", txq.size());
    end
    bus_if.tx_busy = 1'b0;
    expect_ack("busy_release_ack", 8'h99, 3);
  endtask

  task automatic test_ferr();
    do_reset();
    expect_ack("ferr_ack_boot", 8'h99, 3);
    send_word(32'h0000_0001);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'hEE, 1'b1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    repeat (2) @(negedge clock);
    tests++;
    if (iq_wd.size() != 1 || iq_wd[0] !== 32'h44332211 || iq_addr[0] !== 12'd0) begin
      fails++;
      $display("FAIL ferr_word: %0d writes, first %08h, expected 1 write of 44332211 at 0",
               iq_wd.size(), (iq_wd.size() != 0) ? iq_wd[0] : 32'h0);
    end
    expect_ack("ferr_ack_done", 8'hAA, 6);
  endtask

  task automatic test_len_zero();
    do_reset();
    expect_ack("len0_ack_boot", 8'h99, 3);
    send_word(32'h0000_0000);
    expect_ack("len0_ack_done", 8'hAA, 6);
    repeat (2) @(negedge clock);
    tests++;
    if (iq_addr.size() != 0 || bus_if.boot_done !== 1'b1) begin
      fails++;
      $display("FAIL len0_state: %0d writes, boot_done %0b, expected 0, 1", iq_addr.size(), bus_if.boot_done);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    expect_ack("mid_ack_boot", 8'h99, 3);
    send_word(32'h0000_0002);
    send_word(32'hDDCC_BBAA);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    tests++;
    if (iq_addr.size() != 1) begin
      fails++;
      $display("FAIL mid_first_word: %0d writes, expected 1", iq_addr.size());
    end
    do_reset();
    expect_ack("mid_ack_reboot", 8'h99, 3);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    repeat (5) @(negedge clock);
    tests++;
    if (iq_addr.size() != 0 || dq.size() != 0) begin
      fails++;
      $display("FAIL mid_no_write: %0d writes, %0d data, expected 0, 0", iq_addr.size(), dq.size());
    end
  endtask

  task automatic test_len_clamp();
    int bad = 0;
    do_reset();
    expect_ack("clamp_ack_boot", 8'h99, 3);
    send_word(32'h0000_2000);
    repeat (2) @(negedge clock);
    tests++;
    if (bus_if.len_err !== 1'b1) begin
      fails++;
      $display("FAIL clamp_len_err: got %0b, expected 1", bus_if.len_err);
    end
    for (int i = 0; i < 4096; i++) begin
      if (i == 4095) begin
        tests++;
        if (txq.size() != 0) begin
          fails++;
          $display("FAIL clamp_early_ack: ACK sent before last program word");
        end
      end
      send_word(32'hA500_0000 | 32'(i));
    end
    expect_ack("clamp_ack_done", 8'hAA, 6);
    tests++;
    if (iq_addr.size() != 4096) begin
      fails++;
      $display("FAIL clamp_count: got %0d writes, expected 4096", iq_addr.size());
    end else begin
      for (int k = 0; k < 4096; k++) begin
        if (iq_addr[k] !== 12'(k) || iq_wd[k] !== (32'hA500_0000 | 32'(k))) bad++;
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL clamp_contents: %0d bad writes, expected 0", bad);
      end
    end
    send_word(32'h1234_5678);
    repeat (2) @(negedge clock);
    tests++;
    if (dq.size() != 1 || dq[0] !== 32'h12345678 || iq_addr.size() != 4096 || bus_if.len_err !== 1'b1) begin
      fails++;
      $display("FAIL clamp_overflow_stream: %0d data, %0d writes, len_err %0b, expected 1 data 12345678, 4096, 1",
               dq.size(), iq_addr.size(), bus_if.len_err);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] exp;
    dq.delete();
    send_byte(8'hEE, 1'b0);
    send_byte(8'hFF, 1'b0);
    repeat (150) @(negedge clock);
    send_word(32'h0403_0201);
    repeat (3) @(negedge clock);
`ifdef UART_DMA_LOADER_RX_TIMEOUT_EN
    exp = 32'h04030201;
`else
    exp = 32'h0201FFEE;
`endif
    tests++;
    if (dq.size() != 1 || dq[0] !== exp) begin
      fails++;
      $display("FAIL timeout_word: %0d words, first %08h, expected 1 word %08h",
               dq.size(), (dq.size() != 0) ? dq[0] : 32'h0, exp);
    end
  endtask

  task automatic test_protocol();
    tests++;
    if (proto_err != 0) begin
      fails++;
      $display("FAIL protocol: %0d strobe rule violations, expected 0", proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_stream();
    test_boot_busy();
    test_ferr();
    test_len_zero();
    test_reset_mid();
    test_len_clamp();
    test_timeout();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
